// File: rtl/ttc_cfg_pkg12.sv
// ttc_cfg_pkg12: shared state encoding, mask bit indices and counter-control bit defaults
package ttc_cfg_pkg12;
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_STOP = 4'd1,
        S_CLK  = 4'd2,
        S_INTV = 4'd3,
        S_M1   = 4'd4,
        S_M2   = 4'd5,
        S_M3   = 4'd6,
        S_IEN  = 4'd7,
        S_CLR  = 4'd8,
        S_GO   = 4'd9,
        S_REL  = 4'd10,
        S_DONE = 4'd11
    } state_e;

    localparam int M_CLK  = 0;
    localparam int M_INTV = 1;
    localparam int M_M1   = 2;
    localparam int M_M2   = 3;
    localparam int M_M3   = 4;
    localparam int M_IEN  = 5;

    localparam int DIS_BIT_DEF = 0;
    localparam int RST_BIT_DEF = 4;

    typedef struct packed {
        logic [5:0]  mask;
        logic [6:0]  clk_ctrl;
        logic [6:0]  cntr_ctrl;
        logic [15:0] interval;
        logic [15:0] match1;
        logic [15:0] match2;
        logic [15:0] match3;
        logic [5:0]  intr_en;
    } cfg_t;
endpackage

// File: rtl/ttc_cfg_seq_lite12.sv
// ttc_cfg_seq_lite12: one-shot register programming sequencer for a timer/counter channel
module ttc_cfg_seq_lite12
    import ttc_cfg_pkg12::*;
#(
    parameter int STOP_FIRST = 1,
    parameter int DIS_BIT    = DIS_BIT_DEF,
    parameter int RST_BIT    = RST_BIT_DEF
) (
    input  logic        pclk12,
    input  logic        p_reset12,
    input  logic        req12,
    input  logic [5:0]  cfg_mask12,
    input  logic [6:0]  cfg_clk_ctrl12,
    input  logic [6:0]  cfg_cntr_ctrl12,
    input  logic [15:0] cfg_interval12,
    input  logic [15:0] cfg_match1_12,
    input  logic [15:0] cfg_match2_12,
    input  logic [15:0] cfg_match3_12,
    input  logic [5:0]  cfg_intr_en12,
    output logic        busy12,
    output logic        ack12,
    output logic [15:0] pwdata12,
    output logic        clk_ctrl_reg_sel12,
    output logic        cntr_ctrl_reg_sel12,
    output logic        interval_reg_sel12,
    output logic        match_1_reg_sel12,
    output logic        match_2_reg_sel12,
    output logic        match_3_reg_sel12,
    output logic        intr_en_reg_sel12,
    output logic        clear_interrupt12
);
    state_e      state_q, state_d;
    cfg_t        shadow_q, shadow_d, cfg_in;
    logic [6:0]  sel_q, sel_d;
    logic [15:0] wdata_q, wdata_d;
    logic        busy_q, ack_q, clr_q;
    logic [6:0]  c_stop, c_go, c_rel;

    assign cfg_in = '{cfg_mask12, cfg_clk_ctrl12, cfg_cntr_ctrl12, cfg_interval12,
                      cfg_match1_12, cfg_match2_12, cfg_match3_12, cfg_intr_en12};

    assign state_d  = (state_q == S_IDLE) ? (req12 ? S_STOP : S_IDLE) :
                      (state_q == S_DONE) ? S_IDLE : state_e'(state_q + 4'd1);
    assign shadow_d = (state_q == S_IDLE && req12) ? cfg_in : shadow_q;

    always_comb begin
        c_stop          = shadow_d.cntr_ctrl;
        c_stop[DIS_BIT] = 1'b1;
        c_stop[RST_BIT] = 1'b0;
        c_go            = shadow_d.cntr_ctrl;
        c_go[DIS_BIT]   = 1'b0;
        c_go[RST_BIT]   = 1'b1;
        c_rel           = shadow_d.cntr_ctrl;
        c_rel[DIS_BIT]  = 1'b0;
        c_rel[RST_BIT]  = 1'b0;
    end

    // Outputs are decoded from the next state so data/select appear in the cycle of that state.
    always_comb begin
        sel_d   = '0;
        wdata_d = '0;
        case (state_d)
            S_STOP: if (STOP_FIRST != 0) begin sel_d[1] = 1'b1; wdata_d = {9'd0, c_stop}; end
            S_CLK:  if (shadow_d.mask[M_CLK])  begin sel_d[0] = 1'b1; wdata_d = {9'd0, shadow_d.clk_ctrl}; end
            S_INTV: if (shadow_d.mask[M_INTV]) begin sel_d[2] = 1'b1; wdata_d = shadow_d.interval; end
            S_M1:   if (shadow_d.mask[M_M1])   begin sel_d[3] = 1'b1; wdata_d = shadow_d.match1; end
            S_M2:   if (shadow_d.mask[M_M2])   begin sel_d[4] = 1'b1; wdata_d = shadow_d.match2; end
            S_M3:   if (shadow_d.mask[M_M3])   begin sel_d[5] = 1'b1; wdata_d = shadow_d.match3; end
            S_IEN:  if (shadow_d.mask[M_IEN])  begin sel_d[6] = 1'b1; wdata_d = {10'd0, shadow_d.intr_en}; end
            S_GO:   begin sel_d[1] = 1'b1; wdata_d = {9'd0, c_go}; end
            S_REL:  begin sel_d[1] = 1'b1; wdata_d = {9'd0, c_rel}; end
            default: ;
        endcase
    end

    always_ff @(posedge pclk12 or posedge p_reset12) begin
        if (p_reset12) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            sel_q    <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            wdata_q  <= wdata_d;
            busy_q   <= state_d != S_IDLE && state_d != S_DONE;
            ack_q    <= state_d == S_DONE;
            clr_q    <= state_d == S_CLR;
        end
    end

    assign busy12              = busy_q;
    assign ack12               = ack_q;
    assign pwdata12            = wdata_q;
    assign clear_interrupt12   = clr_q;
    assign clk_ctrl_reg_sel12  = sel_q[0];
    assign cntr_ctrl_reg_sel12 = sel_q[1];
    assign interval_reg_sel12  = sel_q[2];
    assign match_1_reg_sel12   = sel_q[3];
    assign match_2_reg_sel12   = sel_q[4];
    assign match_3_reg_sel12   = sel_q[5];
    assign intr_en_reg_sel12   = sel_q[6];
endmodule

// File: tb/tb_ttc_cfg_seq_lite12.sv
// tb_ttc_cfg_seq_lite12: directed table-driven bench for the configuration sequencer
module tb_ttc_cfg_seq_lite12;
    typedef struct packed {
        logic [6:0]  sel;
        logic [15:0] data;
        logic        clr;
        logic        ack;
        logic        busy;
    } exp_t;

    typedef struct {
        logic [5:0]  mask;
        logic [6:0]  clk;
        logic [6:0]  cntr;
        logic [15:0] intv;
        logic [15:0] m1;
        logic [15:0] m2;
        logic [15:0] m3;
        logic [5:0]  ien;
        exp_t        e [1:11];
    } vec_t;

    logic        pclk12 = 1'b0;
    logic        p_reset12 = 1'b1;
    logic        req12 = 1'b0;
    logic [5:0]  cfg_mask12 = '0;
    logic [6:0]  cfg_clk_ctrl12 = '0;
    logic [6:0]  cfg_cntr_ctrl12 = '0;
    logic [15:0] cfg_interval12 = '0;
    logic [15:0] cfg_match1_12 = '0;
    logic [15:0] cfg_match2_12 = '0;
    logic [15:0] cfg_match3_12 = '0;
    logic [5:0]  cfg_intr_en12 = '0;

    logic        busy_a, ack_a, clr_a, busy_b, ack_b, clr_b;
    logic [15:0] data_a, data_b;
    logic [6:0]  sel_a, sel_b;
    exp_t        o_a, o_b;

    int tests = 0;
    int fails = 0;
    int onehot_viol = 0;
    vec_t vecs [0:1];

    always #5 pclk12 = ~pclk12;

    ttc_cfg_seq_lite12 #(.STOP_FIRST(1)) dut_a (
        .pclk12(pclk12), .p_reset12(p_reset12), .req12(req12),
        .cfg_mask12(cfg_mask12), .cfg_clk_ctrl12(cfg_clk_ctrl12), .cfg_cntr_ctrl12(cfg_cntr_ctrl12),
        .cfg_interval12(cfg_interval12), .cfg_match1_12(cfg_match1_12), .cfg_match2_12(cfg_match2_12),
        .cfg_match3_12(cfg_match3_12), .cfg_intr_en12(cfg_intr_en12),
        .busy12(busy_a), .ack12(ack_a), .pwdata12(data_a),
        .clk_ctrl_reg_sel12(sel_a[0]), .cntr_ctrl_reg_sel12(sel_a[1]), .interval_reg_sel12(sel_a[2]),
        .match_1_reg_sel12(sel_a[3]), .match_2_reg_sel12(sel_a[4]), .match_3_reg_sel12(sel_a[5]),
        .intr_en_reg_sel12(sel_a[6]), .clear_interrupt12(clr_a)
    );

    ttc_cfg_seq_lite12 #(.STOP_FIRST(0)) dut_b (
        .pclk12(pclk12), .p_reset12(p_reset12), .req12(req12),
        .cfg_mask12(cfg_mask12), .cfg_clk_ctrl12(cfg_clk_ctrl12), .cfg_cntr_ctrl12(cfg_cntr_ctrl12),
        .cfg_interval12(cfg_interval12), .cfg_match1_12(cfg_match1_12), .cfg_match2_12(cfg_match2_12),
        .cfg_match3_12(cfg_match3_12), .cfg_intr_en12(cfg_intr_en12),
        .busy12(busy_b), .ack12(ack_b), .pwdata12(data_b),
        .clk_ctrl_reg_sel12(sel_b[0]), .cntr_ctrl_reg_sel12(sel_b[1]), .interval_reg_sel12(sel_b[2]),
        .match_1_reg_sel12(sel_b[3]), .match_2_reg_sel12(sel_b[4]), .match_3_reg_sel12(sel_b[5]),
        .intr_en_reg_sel12(sel_b[6]), .clear_interrupt12(clr_b)
    );

    assign o_a = {sel_a, data_a, clr_a, ack_a, busy_a};
    assign o_b = {sel_b, data_b, clr_b, ack_b, busy_b};

    always @(negedge pclk12)
        if ($countones(sel_a) > 1 || $countones(sel_b) > 1) onehot_viol++;

    task automatic tick;
        @(posedge pclk12);
        #1;
    endtask

    task automatic chk(input string name, input exp_t act, input exp_t want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got sel=%b data=%h clr=%b ack=%b busy=%b, want sel=%b data=%h clr=%b ack=%b busy=%b",
                     name, act.sel, act.data, act.clr, act.ack, act.busy,
                     want.sel, want.data, want.clr, want.ack, want.busy);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int want);
        tests++;
        if (act != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic apply_cfg(input int v);
        cfg_mask12      = vecs[v].mask;
        cfg_clk_ctrl12  = vecs[v].clk;
        cfg_cntr_ctrl12 = vecs[v].cntr;
        cfg_interval12  = vecs[v].intv;
        cfg_match1_12   = vecs[v].m1;
        cfg_match2_12   = vecs[v].m2;
        cfg_match3_12   = vecs[v].m3;
        cfg_intr_en12   = vecs[v].ien;
    endtask

    // Expected output of the STOP_FIRST=0 instance: identical except the STOP cycle is silent.
    function automatic exp_t no_stop(input exp_t e, input int k);
        exp_t r = e;
        if (k == 1) begin r.sel = '0; r.data = '0; end
        return r;
    endfunction

    initial begin
        int n_ack;
        int ack_at [0:3];
        vecs[0].mask = 6'h3F; vecs[0].clk = 7'h05; vecs[0].cntr = 7'h22; vecs[0].intv = 16'h1234;
        vecs[0].m1 = 16'h0010; vecs[0].m2 = 16'h0020; vecs[0].m3 = 16'h0030; vecs[0].ien = 6'h3F;
        vecs[0].e[1]  = '{7'b0000010, 16'h0023, 1'b0, 1'b0, 1'b1};
        vecs[0].e[2]  = '{7'b0000001, 16'h0005, 1'b0, 1'b0, 1'b1};
        vecs[0].e[3]  = '{7'b0000100, 16'h1234, 1'b0, 1'b0, 1'b1};
        vecs[0].e[4]  = '{7'b0001000, 16'h0010, 1'b0, 1'b0, 1'b1};
        vecs[0].e[5]  = '{7'b0010000, 16'h0020, 1'b0, 1'b0, 1'b1};
        vecs[0].e[6]  = '{7'b0100000, 16'h0030, 1'b0, 1'b0, 1'b1};
        vecs[0].e[7]  = '{7'b1000000, 16'h003F, 1'b0, 1'b0, 1'b1};
        vecs[0].e[8]  = '{7'b0000000, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[0].e[9]  = '{7'b0000010, 16'h0032, 1'b0, 1'b0, 1'b1};
        vecs[0].e[10] = '{7'b0000010, 16'h0022, 1'b0, 1'b0, 1'b1};
        vecs[0].e[11] = '{7'b0000000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[1].mask = 6'b000010; vecs[1].clk = 7'h7F; vecs[1].cntr = 7'h22; vecs[1].intv = 16'hBEEF;
        vecs[1].m1 = 16'hAAAA; vecs[1].m2 = 16'h5555; vecs[1].m3 = 16'hFFFF; vecs[1].ien = 6'h2A;
        vecs[1].e = vecs[0].e;
        vecs[1].e[2] = '{7'b0000000, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[1].e[3] = '{7'b0000100, 16'hBEEF, 1'b0, 1'b0, 1'b1};
        for (int k = 4; k <= 7; k++) vecs[1].e[k] = '{7'b0000000, 16'h0000, 1'b0, 1'b0, 1'b1};

        tick;
        tick;
        chk("reset_a", o_a, '0);
        chk("reset_b", o_b, '0);
        p_reset12 = 1'b0;
        tick;
        chk("idle_a", o_a, '0);

        for (int v = 0; v < 2; v++) begin
            apply_cfg(v);
            req12 = 1'b1;
            for (int k = 1; k <= 11; k++) begin
                tick;
                req12 = 1'b0;
                chk($sformatf("vec%0d_c%0d_a", v, k), o_a, vecs[v].e[k]);
                chk($sformatf("vec%0d_c%0d_b", v, k), o_b, no_stop(vecs[v].e[k], k));
            end
            tick;
            chk($sformatf("vec%0d_idle", v), o_a, '0);
        end

        apply_cfg(0);
        req12 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            req12 = 1'b0;
            chk($sformatf("chg_c%0d", k), o_a, vecs[0].e[k]);
            if (k == 2) cfg_interval12 = 16'hFFFF;
            if (k == 3 || k == 5 || k == 11) req12 = 1'b1;
        end
        n_ack = 0;
        for (int c = 0; c < 15; c++) begin
            tick;
            req12 = 1'b0;
            if (ack_a || busy_a) n_ack++;
        end
        chk_int("ignored_req_no_restart", n_ack, 0);

        apply_cfg(0);
        req12 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick;
            req12 = 1'b0;
        end
        chk("pre_abort_m2", o_a, vecs[0].e[5]);
        #2 p_reset12 = 1'b1;
        #1 chk("async_abort_a", o_a, '0);
        chk("async_abort_b", o_b, '0);
        tick;
        p_reset12 = 1'b0;
        tick;
        chk("post_abort_idle", o_a, '0);
        req12 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            req12 = 1'b0;
            chk($sformatf("fresh_c%0d", k), o_a, vecs[0].e[k]);
        end

        tick;
        apply_cfg(0);
        req12 = 1'b1;
        n_ack = 0;
        for (int c = 1; c <= 30; c++) begin
            tick;
            if (ack_a && n_ack < 4) begin ack_at[n_ack] = c; n_ack++; end
        end
        req12 = 1'b0;
        chk_int("b2b_ack_count", n_ack, 2);
        if (n_ack >= 2) begin
            chk_int("b2b_first_ack", ack_at[0], 11);
            chk_int("b2b_ack_spacing", ack_at[1] - ack_at[0], 12);
        end else begin
            fails++;
            $display("FAIL b2b_acks: got %0d acks, want 2", n_ack);
        end
        for (int c = 0; c < 14; c++) tick;
        chk("b2b_final_idle", o_a, '0);
        chk_int("onehot_selects", onehot_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
